px_vram_arbiter: RTL and testbench

Single-port arbiter for the pixel-plane VRAM. During active video it hands the RAM port to the pixel engine unchanged. CPU read/write commands are queued in a small command FIFO and executed only while `blank` is high. It sits between the memory unit, the pixel engine and the VRAMpixel block, on the pixel clock domain.

---
 rtl/gpu_pkg.sv | 14 +
 rtl/px_cmd_fifo.sv | 59 +++++
 rtl/px_vram_arbiter.sv | 111 +++++++++++
 tb/tb_px_vram_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared types for the pixel-plane VRAM path: arbiter state and the queued CPU command.
package gpu_pkg;
    localparam int PX_AW = 17;
    localparam int PX_DW = 8;
    localparam int CMD_W = 1 + PX_AW + PX_DW;

    typedef enum logic {S_IDLE, S_RD} state_t;

    typedef struct packed {
        logic              we;
        logic [PX_AW-1:0]  addr;
        logic [PX_DW-1:0]  data;
    } cmd_t;
endpackage

// File: rtl/px_cmd_fifo.sv
// Synchronous command FIFO with a registered head; storage is plain (distributed) RAM.
module px_cmd_fifo
    import gpu_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int W     = CMD_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic [W-1:0]  r_head;

    logic          w_push;
    logic          w_pop;
    logic [PW-1:0] w_rd_nxt;

    assign full     = (r_level == LW'(DEPTH));
    assign empty    = (r_level == '0);
    assign w_push   = push && !full;
    assign w_pop    = pop && !empty;
    assign w_rd_nxt = r_rd_ptr + PW'(w_pop);
    assign head     = r_head;
    assign level    = r_level;

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= din;
    end

    // The head register preloads whichever entry becomes the head after this edge,
    // bypassing the RAM when that entry is the one being written right now.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_head   <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PW'(w_push);
            r_rd_ptr <= w_rd_nxt;
            r_level  <= r_level + LW'(w_push) - LW'(w_pop);
            r_head   <= (w_push && (r_wr_ptr == w_rd_nxt)) ? din : r_mem[w_rd_nxt];
        end
    end
endmodule

// File: rtl/px_vram_arbiter.sv
// VRAM port arbiter: pixel engine owns the port in active video, queued CPU commands run during blank.
module px_vram_arbiter
    import gpu_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 17,
    parameter int DW    = 8
) (
    input  logic                    clkPixel,
    input  logic                    reset,
    input  logic                    blank,
    input  logic                    cpu_valid,
    output logic                    cpu_ready,
    input  logic                    cpu_we,
    input  logic [AW-1:0]           cpu_addr,
    input  logic [DW-1:0]           cpu_data,
    output logic [DW-1:0]           cpu_q,
    output logic                    cpu_rvalid,
    output logic [$clog2(DEPTH):0]  fifo_level,
    input  logic [AW-1:0]           gpu_addr,
    output logic [DW-1:0]           gpu_q,
    output logic [AW-1:0]           ram_addr,
    output logic [DW-1:0]           ram_d,
    output logic                    ram_we,
    input  logic [DW-1:0]           ram_q
);
    localparam int CW = 1 + AW + DW;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } px_cmd_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [DW-1:0] r_cpu_q;
    logic          r_rvalid;

    px_cmd_t       w_push_cmd;
    px_cmd_t       w_head;
    logic [CW-1:0] w_head_raw;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_capture;

    assign w_push_cmd = '{we: cpu_we, addr: cpu_addr, data: cpu_data};
    assign w_head     = w_head_raw;

    px_cmd_fifo #(.DEPTH(DEPTH), .W(CW)) u_fifo (
        .clk   (clkPixel),
        .reset (reset),
        .push  (cpu_valid),
        .din   (w_push_cmd),
        .pop   (w_pop),
        .head  (w_head_raw),
        .level (fifo_level),
        .full  (w_full),
        .empty (w_empty)
    );

    assign cpu_ready  = !w_full;
    assign gpu_q      = ram_q;
    assign cpu_q      = r_cpu_q;
    assign cpu_rvalid = r_rvalid;

    // Reset masks the port so nothing queued before the flush reaches the RAM.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_capture   = 1'b0;
        ram_addr    = gpu_addr;
        ram_d       = '0;
        ram_we      = 1'b0;
        if (!reset) begin
            case (r_state)
                S_IDLE: begin
                    if (blank && !w_empty) begin
                        w_pop    = 1'b1;
                        ram_addr = w_head.addr;
                        if (w_head.we) begin
                            ram_we = 1'b1;
                            ram_d  = w_head.data;
                        end else begin
                            w_state_nxt = S_RD;
                        end
                    end
                end
                S_RD: begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clkPixel) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cpu_q  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_rvalid <= w_capture;
            if (w_capture)
                r_cpu_q <= ram_q;
        end
    end
endmodule

// File: tb/tb_px_vram_arbiter.sv
// Self-checking bench: transaction-level model of the command queue and VRAM, plus directed scenarios.
module tb_px_vram_arbiter;
    localparam int DEPTH = 16;
    localparam int AW    = 17;
    localparam int DW    = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          blank = 1'b0;
    logic          cpu_valid = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_data = '0;
    logic [AW-1:0] gpu_addr = '0;
    logic          cpu_ready;
    logic [DW-1:0] cpu_q;
    logic          cpu_rvalid;
    logic [LW-1:0] fifo_level;
    logic [DW-1:0] gpu_q;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_d;
    logic          ram_we;
    logic [DW-1:0] ram_q = '0;

    always #5 clk = ~clk;

    px_vram_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clkPixel(clk), .reset(reset), .blank(blank),
        .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_q(cpu_q),
        .cpu_rvalid(cpu_rvalid), .fifo_level(fifo_level),
        .gpu_addr(gpu_addr), .gpu_q(gpu_q), .ram_addr(ram_addr),
        .ram_d(ram_d), .ram_we(ram_we), .ram_q(ram_q)
    );

    logic [DW-1:0] vram  [0:(1<<AW)-1];
    logic [DW-1:0] m_mem [0:(1<<AW)-1];

    function automatic logic [DW-1:0] init_val(int a);
        return 8'(a ^ (a >> 8) ^ 8'h3C);
    endfunction

    // Physical VRAM: registered read, old data on a same-cycle write.
    always @(posedge clk) begin
        if (ram_we) vram[ram_addr] <= ram_d;
        ram_q <= vram[ram_addr];
    end

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } cmd_s;

    cmd_s          mq[$];
    int            rv_cyc[$];
    logic [DW-1:0] rv_dat[$];
    int            free_cyc = 0;
    bit            mvalid = 0;
    bit            gq_valid = 0;
    logic [DW-1:0] exp_gq;

    // Model: commands leave the queue in order, one per blank cycle; a read blocks the port
    // for the following cycle and its data shows up two cycles after it leaves.
    always @(negedge clk) begin
        cmd_s          h;
        cmd_s          n;
        int            lvl0;
        bit            e_rv;
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_d;
        lvl0 = mq.size();
        if (mvalid) begin
            chk("level", 32'(fifo_level), 32'(lvl0));
            chk("ready", 32'(cpu_ready), 32'(lvl0 < DEPTH));
            e_rv = (rv_cyc.size() > 0) && (rv_cyc[0] == cyc);
            chk("rvalid", 32'(cpu_rvalid), 32'(e_rv));
            if (e_rv) begin
                chk("cpu_q", 32'(cpu_q), 32'(rv_dat[0]));
                void'(rv_cyc.pop_front());
                void'(rv_dat.pop_front());
            end
            if (gq_valid) chk("gpu_q", 32'(gpu_q), 32'(exp_gq));
            e_we = 1'b0; e_addr = gpu_addr; e_d = '0;
            if (!reset && blank && lvl0 > 0 && cyc >= free_cyc) begin
                h = mq.pop_front();
                e_addr = h.addr;
                if (h.we) begin
                    e_we = 1'b1; e_d = h.data;
                end else begin
                    rv_cyc.push_back(cyc + 2);
                    rv_dat.push_back(m_mem[h.addr]);
                    free_cyc = cyc + 2;
                end
            end
            chk("ram_we", 32'(ram_we), 32'(e_we));
            chk("ram_addr", 32'(ram_addr), 32'(e_addr));
            chk("ram_d", 32'(ram_d), 32'(e_d));
            exp_gq = m_mem[e_addr];
            gq_valid = 1;
            if (e_we) m_mem[e_addr] = e_d;
            if (!reset && cpu_valid && lvl0 < DEPTH) begin
                n.we = cpu_we; n.addr = cpu_addr; n.data = cpu_data;
                mq.push_back(n);
            end
        end
        if (reset) begin
            mq.delete(); rv_cyc.delete(); rv_dat.delete();
            free_cyc = cyc + 1;
            mvalid = 1;
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic offer(logic we, logic [AW-1:0] a, logic [DW-1:0] d);
        cpu_valid = 1'b1; cpu_we = we; cpu_addr = a; cpu_data = d;
        step();
        cpu_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int n_we, n_rv, pop_t, rv_t, blank_left;
        logic [DW-1:0] q;
        for (int i = 0; i < (1 << AW); i++) begin
            vram[i]  = init_val(i);
            m_mem[i] = init_val(i);
        end
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(cpu_ready), 32'd1);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_rvalid", 32'(cpu_rvalid), 32'd0);
        chk("rst_cpu_q", 32'(cpu_q), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_ram_d", 32'(ram_d), 32'd0);
        @(posedge clk); #1;

        // Active video sweep.
        blank = 1'b0;
        for (int i = 0; i < 640; i++) begin
            gpu_addr = AW'(i);
            step();
        end

        // Fill the queue in active video, then drain it in one blanking burst.
        for (int i = 0; i < 16; i++) offer(1'b1, AW'(32'h100 + i), DW'(i));
        cpu_valid = 1'b1; cpu_we = 1'b1; cpu_addr = 17'h00200; cpu_data = 8'hEE;
        @(negedge clk);
        chk("full_ready", 32'(cpu_ready), 32'd0);
        chk("full_level", 32'(fifo_level), 32'd16);
        @(posedge clk); #1;
        cpu_valid = 1'b0; blank = 1'b1;
        n_we = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk); if (ram_we) n_we++;
            @(posedge clk); #1;
        end
        chk("burst_we", 32'(n_we), 32'd16);
        @(negedge clk);
        chk("drained", 32'(fifo_level), 32'd0);
        chk("refused17", 32'(vram[17'h00200]), 32'(init_val(32'h200)));
        chk("wr_0x10f", 32'(vram[17'h0010F]), 32'd15);
        @(posedge clk); #1;

        // Write then read-back at the top address.
        blank = 1'b0; gpu_addr = '0;
        offer(1'b1, 17'h1FFFF, 8'hA5);
        offer(1'b0, 17'h1FFFF, 8'h00);
        blank = 1'b1;
        pop_t = -100; rv_t = -1; q = '0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (pop_t < 0 && ram_addr == 17'h1FFFF && !ram_we) pop_t = t;
            if (rv_t < 0 && cpu_rvalid) begin rv_t = t; q = cpu_q; end
            @(posedge clk); #1;
        end
        chk("rd_latency", 32'(rv_t - pop_t), 32'd2);
        chk("rd_data", 32'(q), 32'hA5);

        // Blank falls part way through a batch of 8 writes.
        blank = 1'b0; gpu_addr = 17'h00300;
        for (int i = 0; i < 8; i++) offer(1'b1, AW'(32'h400 + i), DW'(32'h80 + i));
        blank = 1'b1; n_we = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); if (ram_we) n_we++;
            @(posedge clk); #1;
        end
        chk("part_we", 32'(n_we), 32'd3);
        blank = 1'b0; n_we = 0;
        @(negedge clk);
        chk("part_level", 32'(fifo_level), 32'd5);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); if (ram_we) n_we++;
            @(posedge clk); #1;
            gpu_addr = AW'($urandom);
        end
        chk("active_we", 32'(n_we), 32'd0);
        blank = 1'b1; n_we = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); if (ram_we) n_we++;
            @(posedge clk); #1;
        end
        chk("rest_we", 32'(n_we), 32'd5);
        chk("rest_last", 32'(vram[17'h00407]), 32'h87);

        // Read popped on the last blank cycle.
        blank = 1'b0; gpu_addr = 17'h00777;
        offer(1'b0, 17'h05555, 8'h00);
        blank = 1'b1;
        @(negedge clk);
        chk("last_pop", 32'(ram_addr), 32'h05555);
        @(posedge clk); #1;
        blank = 1'b0; gpu_addr = 17'h0ABCD;
        @(negedge clk);
        chk("gpu_takes", 32'(ram_addr), 32'h0ABCD);
        @(posedge clk); #1;
        @(negedge clk);
        chk("late_rvalid", 32'(cpu_rvalid), 32'd1);
        chk("late_q", 32'(cpu_q), 32'(init_val(32'h05555)));
        @(posedge clk); #1;

        // Reset with a read in flight and four commands queued.
        offer(1'b0, 17'h00010, 8'h00);
        for (int i = 0; i < 4; i++) offer(1'b1, AW'(32'h600 + i), 8'h55);
        blank = 1'b1;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_flush", 32'(fifo_level), 32'd0);
        @(posedge clk); #1;
        n_we = 0; n_rv = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ram_we) n_we++;
            if (cpu_rvalid) n_rv++;
            @(posedge clk); #1;
        end
        chk("rst_no_we", 32'(n_we), 32'd0);
        chk("rst_no_rv", 32'(n_rv), 32'd0);
        chk("rst_no_wr", 32'(vram[17'h00600]), 32'(init_val(32'h600)));

        // Random traffic against the model.
        blank_left = 0;
        for (int i = 0; i < 4000; i++) begin
            if (blank_left == 0) begin
                blank = ~blank;
                blank_left = $urandom_range(1, 40);
            end
            blank_left--;
            cpu_valid = ($urandom_range(0, 2) != 0);
            cpu_we    = $urandom_range(0, 1);
            cpu_addr  = ($urandom_range(0, 7) == 0) ? 17'h1FFFF : AW'(32'h1F000 + $urandom_range(0, 15));
            cpu_data  = DW'($urandom);
            gpu_addr  = AW'($urandom);
            reset     = ($urandom_range(0, 499) == 0);
            step();
        end
        reset = 1'b0; cpu_valid = 1'b0; blank = 1'b1;
        repeat (40) step();
        chk("final_level", 32'(fifo_level), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
